// File: rtl/baud_pkg.sv
// baud_pkg: shared state type, divisor limits and helpers for the fractional baud-rate generator.
package baud_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DIV_MIN        = 2;
    localparam int DEF_DIV_INT_C  = 164;
    localparam int DEF_DIV_FRAC_C = 0;

    // Ceiling log2, used to size the oversample index from OS.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// baud_frac_acc: fractional phase accumulator; carry stretches the next period by one cycle.
module baud_frac_acc
    import baud_pkg::*;
#(
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FRAC_W-1:0] act_frac,
    input  logic              step,
    input  logic              clear,
    output logic              carry
);

    logic [FRAC_W-1:0] facc_r;
    logic [FRAC_W:0]   sum_s;

    // Sum of the running fraction and the fraction in force for the coming period.
    always_comb begin
        sum_s = {1'b0, facc_r} + {1'b0, act_frac};
    end

    assign carry = sum_s[FRAC_W];

    // Accumulator register: clear has priority so a restart always begins at phase zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            facc_r <= {FRAC_W{1'b0}};
        end else if (clear) begin
            facc_r <= {FRAC_W{1'b0}};
        end else if (step) begin
            facc_r <= sum_s[FRAC_W-1:0];
        end else begin
            facc_r <= facc_r;
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: programmable fractional baud-rate generator with oversample, mid-bit and end-of-bit ticks.
// Divisor writes land in a shadow pair and reach the active pair only at a period boundary or on enable.
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OS           = 16,
    parameter int DEF_DIV_INT  = DEF_DIV_INT_C,
    parameter int DEF_DIV_FRAC = DEF_DIV_FRAC_C
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cfg_we,
    input  logic [DIV_W-1:0]     cfg_div_int,
    input  logic [FRAC_W-1:0]    cfg_div_frac,
    input  logic                 resync,
    output logic                 tick,
    output logic                 tick_mid,
    output logic                 tick_bit,
    output logic [clog2(OS)-1:0] os_idx,
    output logic                 cfg_err
);

    localparam int               IDX_W     = clog2(OS);
    localparam logic [IDX_W-1:0] IDX_MID   = IDX_W'(OS / 2);
    localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_MIN_V = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] ONE_V     = DIV_W'(1);
    localparam logic [DIV_W-1:0] ZERO_V    = {DIV_W{1'b0}};

    state_t             state_r;
    state_t             state_s;
    logic [DIV_W-1:0]   sh_int_r;
    logic [FRAC_W-1:0]  sh_frac_r;
    logic [DIV_W-1:0]   act_int_r;
    logic [FRAC_W-1:0]  act_frac_r;
    logic [DIV_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   os_idx_r;
    logic               tick_r;
    logic               tick_mid_r;
    logic               tick_bit_r;
    logic               cfg_err_r;

    logic               cfg_low_s;
    logic [DIV_W-1:0]   sh_int_s;
    logic [FRAC_W-1:0]  sh_frac_s;
    logic [DIV_W-1:0]   act_int_s;
    logic [FRAC_W-1:0]  act_frac_s;
    logic               start_s;
    logic               run_s;
    logic               resync_s;
    logic               boundary_s;
    logic               clear_s;
    logic               carry_s;
    logic [IDX_W-1:0]   os_next_s;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: en alone decides between IDLE and RUN, so a falling en beats resync.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (!en) begin
                    state_s = IDLE;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Shadow-pair next value; too-small integer divisors are clamped to the minimum.
    always_comb begin
        cfg_low_s = (cfg_div_int < DIV_MIN_V);
        sh_int_s  = sh_int_r;
        sh_frac_s = sh_frac_r;
        if (cfg_we) begin
            sh_int_s  = cfg_low_s ? DIV_MIN_V : cfg_div_int;
            sh_frac_s = cfg_div_frac;
        end else begin
            sh_int_s  = sh_int_r;
            sh_frac_s = sh_frac_r;
        end
    end

    // Event decode for this cycle: start, restart, period boundary, plain counting.
    always_comb begin
        start_s    = 1'b0;
        run_s      = 1'b0;
        resync_s   = 1'b0;
        boundary_s = 1'b0;
        if (state_r == RUN) begin
            run_s      = en;
            resync_s   = en & resync;
            boundary_s = en & ~resync & (cnt_r == ZERO_V);
        end else begin
            start_s    = en;
        end
        clear_s   = ~run_s | resync_s;
        os_next_s = os_idx_r + IDX_W'(1);
    end

    // Active pair as it will be after this edge; a same-cycle write flows straight through.
    always_comb begin
        act_int_s  = act_int_r;
        act_frac_s = act_frac_r;
        if (start_s | boundary_s) begin
            act_int_s  = sh_int_s;
            act_frac_s = sh_frac_s;
        end else begin
            act_int_s  = act_int_r;
            act_frac_s = act_frac_r;
        end
    end

    baud_frac_acc #(
        .FRAC_W   (FRAC_W)
    ) u_frac_acc (
        .clk      (clk),
        .rst      (rst),
        .act_frac (act_frac_s),
        .step     (boundary_s),
        .clear    (clear_s),
        .carry    (carry_s)
    );

    // Shadow and active divisor registers plus the sticky configuration error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_int_r   <= DIV_W'(DEF_DIV_INT);
            sh_frac_r  <= FRAC_W'(DEF_DIV_FRAC);
            act_int_r  <= DIV_W'(DEF_DIV_INT);
            act_frac_r <= FRAC_W'(DEF_DIV_FRAC);
            cfg_err_r  <= 1'b0;
        end else begin
            sh_int_r   <= sh_int_s;
            sh_frac_r  <= sh_frac_s;
            act_int_r  <= act_int_s;
            act_frac_r <= act_frac_s;
            cfg_err_r  <= cfg_err_r | (cfg_we & cfg_low_s);
        end
    end

    // Period down-counter; a boundary reload adds the accumulator carry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= ZERO_V;
        end else if (start_s) begin
            cnt_r <= act_int_s - ONE_V;
        end else if (resync_s) begin
            cnt_r <= act_int_r - ONE_V;
        end else if (boundary_s) begin
            cnt_r <= act_int_s - ONE_V + DIV_W'(carry_s);
        end else if (run_s) begin
            cnt_r <= cnt_r - ONE_V;
        end else begin
            cnt_r <= ZERO_V;
        end
    end

    // Oversample index and registered tick strobes, all decoded from the same boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            os_idx_r   <= IDX_ZERO;
            tick_r     <= 1'b0;
            tick_mid_r <= 1'b0;
            tick_bit_r <= 1'b0;
        end else begin
            tick_r     <= boundary_s;
            tick_mid_r <= boundary_s & (os_next_s == IDX_MID);
            tick_bit_r <= boundary_s & (os_next_s == IDX_ZERO);
            if (boundary_s) begin
                os_idx_r <= os_next_s;
            end else if (run_s & ~resync_s) begin
                os_idx_r <= os_idx_r;
            end else begin
                os_idx_r <= IDX_ZERO;
            end
        end
    end

    assign tick     = tick_r;
    assign tick_mid = tick_mid_r;
    assign tick_bit = tick_bit_r;
    assign os_idx   = os_idx_r;
    assign cfg_err  = cfg_err_r;

endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Parametrised fractional baud-rate generator for the debug UART. It produces a one-cycle oversample tick at a programmable fractional divisor, plus derived mid-bit and end-of-bit strobes. It also supports phase re-alignment on a detected start bit. It feeds the UART RX/TX bit engines in the debugger unit and replaces the fixed-divisor tick generator.

## Interface
Parameters:
- DIV_W, 16: width of integer divisor.
- FRAC_W, 4: width of fractional divisor, in 1/2^FRAC_W cycle units.
- OS, 16: oversample ticks per bit; power of two, ≥4.
- DEF_DIV_INT, 164: integer divisor loaded at reset.
- DEF_DIV_FRAC, 0: fractional divisor loaded at reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low = idle, no ticks.
- cfg_we  in  1  one-cycle write strobe for divisor shadow registers.
- cfg_div_int  in  DIV_W  integer divisor, sampled on cfg_we.
- cfg_div_frac  in  FRAC_W  fractional divisor, sampled on cfg_we.
- resync  in  1  one-cycle phase restart (RX start-bit edge).
- tick  out  1  oversample tick; one cycle wide.
- tick_mid  out  1  coincides with the tick on which os_idx becomes OS/2.
- tick_bit  out  1  coincides with the tick on which os_idx wraps OS-1→0.
- os_idx  out  $clog2(OS)  oversample index since last resync/enable.
- cfg_err  out  1  sticky; set when a written cfg_div_int < 2.

## Operation
- Registers:
  - shadow pair (sh_int, sh_frac);
  - active pair (act_int, act_frac);
  - down-counter cnt (DIV_W);
  - accumulator facc (FRAC_W);
  - os_idx;
  - state.
- States:
  - IDLE: cnt, facc, os_idx held at 0; no ticks.
  - RUN: counting.
- Transitions:
  - IDLE→RUN when en=1: copy shadow→active, cnt ← act_int-1, facc ← 0.
  - RUN→IDLE when en=0: counters cleared the same edge; no tick in that cycle.
- In RUN:
  - cnt decrements each cycle.
  - When cnt==0: tick asserts, os_idx increments mod OS, and the shadow pair copies to active.
  - The next period then loads cnt ← act_int-1+c, where {c, facc} = facc + act_frac (c = carry).
  - Period is act_int or act_int+1 cycles. Average period is act_int + act_frac/2^FRAC_W.
- cfg_we:
  - Writes the shadow pair in any state.
  - The active pair never changes mid-period.
  - cfg_div_int < 2 is clamped to 2 in the shadow register, and cfg_err is set.
  - cfg_err clears only on reset.
- resync (RUN only; ignored in IDLE):
  - Same edge: cnt ← act_int-1, facc ← 0, os_idx ← 0.
  - No tick, tick_mid or tick_bit in a cycle where resync=1, even if cnt==0.
- Simultaneous events:
  - cfg_we and period boundary in the same cycle: the new value is taken into shadow and into active at that boundary.
  - resync and en falling together: IDLE wins.

## Timing
- Reset values:
  - tick=0, tick_mid=0, tick_bit=0, os_idx=0, cfg_err=0;
  - state=IDLE, cnt=0, facc=0;
  - shadow and active pairs = DEF_DIV_INT/DEF_DIV_FRAC.
- Outputs are registered. tick_mid and tick_bit are never high without tick.
- First tick: with en sampled high at edge E0, tick is high during cycle E0+act_int. Example: 164 cycles after E0.
- Integer-only divisor: tick period is exactly act_int cycles. tick_bit period is OS·act_int cycles.
- Worst-case config latency: shadow to active within one current period plus one cycle.
- Reset mid-period drops any tick in flight. Reset asserted in the same cycle as a tick forces outputs low immediately.

## Structure
- Package baud_pkg:
  - state enum (IDLE, RUN);
  - DIV_MIN=2 constant;
  - default divisor constants;
  - function clog2 for the os_idx width.
- One sub-module, baud_frac_acc:
  - holds the facc register;
  - inputs: act_frac, step (=tick), clear (resync/idle);
  - output: carry c.
- Top holds the FSM, cnt, shadow/active registers and os_idx.

## Test plan
- Reset release, en=1, defaults (164/0): tick every 164 cycles, first at E0+164; tick_bit every 2624 cycles; tick_mid when os_idx=8.
- cfg 10/8 (FRAC_W=4): periods alternate 10,11,10,11; 16 ticks span exactly 168 cycles.
- cfg_we 50/0 written mid-period under 164/0: current period still 164 cycles; following period 50.
- resync on the cycle where cnt==0: no tick that cycle; next tick act_int cycles later with os_idx=1; tick_bit after 16 ticks.
- cfg_div_int=1: shadow=2, cfg_err=1, tick period 2. en low then high: cfg_err stays 1, first tick 2 cycles after en.
- Assert rst mid-period with en=1: all outputs 0 asynchronously; divisor back to 164/0; en still high → first tick 164 cycles after release.
